clk_divider: RTL and testbench

- Parameterised integer clock divider: produces clkOut at f(clkIn)/DIV with ~50% duty cycle.
- Sits beside the FPGA system clock and feeds slower clock domains (peripheral, PWM and debug clocks).
- Odd divisors use both clkIn edges so the duty cycle stays as close to 50% as one half input period allows.
- DIV=1 is a gated pass-through.

---
 rtl/clk_divider.sv | 58 +++++
 tb/tb_clk_divider.sv | 112 +++++++++++
 2 files changed

// File: rtl/clk_divider.sv
// Integer clock divider: clkOut = clkIn / DIV with near-50% duty cycle.
// Odd divisors stretch the high phase by half an input period using the falling edge.
`timescale 1ns/1ps
module clk_divider #(
    parameter int DIV = 2
) (
    input  logic clkIn,
    input  logic rstN,
    output logic clkOut
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int H  = DIV / 2;

    generate
        if (DIV < 1) begin : gBadDiv
            $error("clk_divider: DIV must be >= 1 (got %0d)", DIV);
        end else if (DIV == 1) begin : gPass
            assign clkOut = clkIn & rstN;
        end else begin : gDiv
            logic [CW-1:0] cnt;
            logic [CW-1:0] cntNext;
            logic          p;

            always_comb begin
                cntNext = (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
            end

            // Reset to DIV-1 so the first rising edge after release starts phase 0.
            always_ff @(posedge clkIn or negedge rstN) begin
                if (!rstN) begin
                    cnt <= CW'(DIV - 1);
                    p   <= 1'b0;
                end else begin
                    cnt <= cntNext;
                    p   <= (cntNext < CW'(H));
                end
            end

            if (DIV % 2 == 1) begin : gOdd
                logic n;

                always_ff @(negedge clkIn or negedge rstN) begin
                    if (!rstN) begin
                        n <= 1'b0;
                    end else begin
                        n <= p;
                    end
                end

                assign clkOut = p | n;
            end else begin : gEven
                assign clkOut = p;
            end
        end
    endgenerate

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: DIV = 1..8 side by side, each checked half a period after
// every clkIn edge against a half-period phase model, with random reset pulses.
`timescale 1ns/1ps
module tb_clk_divider;

    logic       clkIn = 1'b0;
    logic       rstN  = 1'b0;
    logic [8:1] obs;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model state: half periods elapsed since the first rising edge after release.
    bit          started  = 1'b0;
    int unsigned h        = 0;
    bit          lastRise = 1'b0;

    always #1 clkIn = ~clkIn;

    for (genvar g = 1; g <= 8; g++) begin : gDut
        clk_divider #(.DIV(g)) dut (
            .clkIn (clkIn),
            .rstN  (rstN),
            .clkOut(obs[g])
        );
    end

    // Output is high for the first DIV half periods of each 2*DIV half-period cycle.
    function automatic logic refOut(int unsigned d, bit st, int unsigned hh);
        return st && ((hh % (2 * d)) < d);
    endfunction

    task automatic checkAll(string tag);
        for (int d = 1; d <= 8; d++) begin
            logic e;
            e = refOut(d, started, h);
            checks++;
            assert (obs[d] === e) else begin
                errors++;
                $error("FAIL %s div=%0d: observed %b expected %b at %0t", tag, d, obs[d], e, $time);
            end
        end
    endtask

    task automatic step(string tag);
        @(clkIn);
        lastRise = clkIn;
        if (!rstN) begin
            started = 1'b0;
        end else if (!started) begin
            if (lastRise) begin
                started = 1'b1;
                h = 0;
            end
        end else begin
            h++;
        end
        #0.5;
        checkAll(tag);
    endtask

    task automatic releaseReset();
        if (lastRise) step("preRelease");
        rstN = 1'b1;
        #0.1;
        checkAll("release");
    endtask

    task automatic assertReset(string tag);
        rstN = 1'b0;
        started = 1'b0;
        #0.1;
        checkAll(tag);
    endtask

    initial begin
        #0.5;
        checkAll("reset");
        for (int i = 0; i < 3; i++) step("inReset");

        releaseReset();
        for (int i = 0; i < 50; i++) step("run");

        // Drop reset while the DIV=4 output is high.
        for (int i = 0; i < 16 && obs[4] !== 1'b1; i++) step("seekHigh");
        checks++;
        assert (obs[4] === 1'b1) else begin
            errors++;
            $error("FAIL seekHigh div=4: observed %b expected 1 within 16 half periods", obs[4]);
        end
        assertReset("asyncReset");
        for (int i = 0; i < int'($urandom_range(2, 6)); i++) step("held");
        releaseReset();
        for (int i = 0; i < 40; i++) step("resume");

        for (int seg = 0; seg < 4; seg++) begin
            int unsigned runLen;
            int unsigned holdLen;
            runLen  = $urandom_range(10, 60);
            holdLen = $urandom_range(1, 5);
            for (int i = 0; i < int'(runLen); i++) step("rndRun");
            assertReset("rndReset");
            for (int i = 0; i < int'(holdLen); i++) step("rndHeld");
            releaseReset();
        end
        for (int i = 0; i < 40; i++) step("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
